fib_seq_arbiter: RTL and testbench

- Shares one Fib_Seq datapath between NUM_REQ requesters.
- Picks a requester round-robin and sequences Fib_Seq: reset pulse, then Start until Done.
- Captures the result and returns it to the granted requester with a one-cycle Ack.
- Sits between client logic and the single Fib_Seq instance. It is the only driver of Fib_Seq's Start, Rst and Number.

---
 rtl/fib_arb_pkg.sv | 18 +
 rtl/fib_rr_picker.sv | 31 +++
 rtl/fib_seq_arbiter.sv | 124 ++++++++++++
 tb/tb_fib_seq_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_arb_pkg.sv
// Shared state encoding and constants for the Fib_Seq request arbiter.
// Default geometry matches the single shared Fib_Seq instance.
package fib_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 10;

  // Wide enough for any supported DATA_W; the top takes the low DATA_W bits.
  localparam logic [31:0] TIMEOUT_RESULT = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } arb_state_e;

endpackage

// File: rtl/fib_rr_picker.sv
// Combinational round-robin pick: first high Req above last_grant, with wrap.
// Zero latency; any_req low means next_idx is don't-care (driven 0).
module fib_rr_picker
  import fib_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] Req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               any_req,
  output logic [IDX_W-1:0]   next_idx
);

  always_comb begin
    logic found;
    int   cand;
    any_req  = |Req;
    next_idx = '0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!found && Req[cand]) begin
        found    = 1'b1;
        next_idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fib_seq_arbiter.sv
// Round-robin sharing of one Fib_Seq among NUM_REQ requesters; Req-to-Ack >= 4 cycles.
// Req is a held level (no backpressure path); FIB_ARB_TIMEOUT_EN adds a RUN watchdog.
module fib_seq_arbiter
  import fib_arb_pkg::*;
#(
  parameter  int NUM_REQ     = NUM_REQ_DEF,
  parameter  int DATA_W      = DATA_W_DEF,
  parameter  int TIMEOUT_CYC = 1023,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [NUM_REQ*DATA_W-1:0] Number,
  output logic [NUM_REQ-1:0]        Ack,
  output logic [DATA_W-1:0]         Result,
  output logic                      Err,
  output logic                      Busy,
  output logic [IDX_W-1:0]          Grant_Id,
  output logic                      Fib_Rst,
  output logic                      Fib_Start,
  output logic [DATA_W-1:0]         Fib_Number,
  input  logic [DATA_W-1:0]         Fib_Result,
  input  logic                      Fib_Done
);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] last_grant;
  logic             any_req;
  logic [IDX_W-1:0] pick_idx;
  logic             run_armed;
  logic             done_hit;
  logic             to_hit;

  fib_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .Req        (Req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .next_idx   (pick_idx)
  );

  // A Done still asserted from the previous job is ignored in the first RUN cycle.
  assign done_hit = (state == RUN) && run_armed && Fib_Done;

  always_comb begin
    state_nxt = state;
    Fib_Rst   = 1'b1;
    Fib_Start = 1'b0;
    Busy      = (state != IDLE);
    Ack       = '0;
    case (state)
      IDLE: if (any_req) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN: begin
        Fib_Rst   = 1'b0;
        Fib_Start = 1'b1;
        if (done_hit || to_hit) state_nxt = RESP;
      end
      RESP: begin
        Ack[Grant_Id] = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      Grant_Id   <= '0;
      Fib_Number <= '0;
      Result     <= '0;
      run_armed  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            Grant_Id   <= pick_idx;
            Fib_Number <= Number[pick_idx*DATA_W +: DATA_W];
          end
        end
        LOAD: run_armed <= 1'b0;
        RUN: begin
          run_armed <= 1'b1;
          if (done_hit)    Result <= Fib_Result;
          else if (to_hit) Result <= TIMEOUT_RESULT[DATA_W-1:0];
        end
        RESP: last_grant <= Grant_Id;
        default: ;
      endcase
    end
  end

`ifdef FIB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // wd_cnt holds the number of RUN cycles already completed.
  assign to_hit = (state == RUN) && !done_hit && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == LOAD)     wd_cnt <= '0;
      else if (state == RUN) wd_cnt <= wd_cnt + 1'b1;
      if (state == RUN)      err_q  <= to_hit;
    end
  end

  assign Err = (state == RESP) && err_q;
`else
  logic to_unused;
  assign to_unused = (TIMEOUT_CYC > 0);
  assign to_hit    = 1'b0;
  assign Err       = 1'b0;
`endif

endmodule

// File: tb/tb_fib_seq_arbiter.sv
// Directed and randomized bench for fib_seq_arbiter with a Fib_Seq stub.
// Expected grants/results come from a transaction-level round-robin model.
module tb_fib_seq_arbiter;

  localparam int NR = 4;
  localparam int DW = 10;
  localparam int TO = 20;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [NR-1:0] Req;
  logic [NR*DW-1:0] Number;
  logic [NR-1:0] Ack;
  logic [DW-1:0] Result;
  logic          Err;
  logic          Busy;
  logic [1:0]    Grant_Id;
  logic          Fib_Rst;
  logic          Fib_Start;
  logic [DW-1:0] Fib_Number;
  logic [DW-1:0] Fib_Result;
  logic          Fib_Done;

  int checks = 0;
  int errors = 0;
  int last_g = NR - 1;
  int lat = 1;
  int stub_cnt = 0;
  logic prev_start = 1'b0;

  fib_seq_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Req        (Req),
    .Number     (Number),
    .Ack        (Ack),
    .Result     (Result),
    .Err        (Err),
    .Busy       (Busy),
    .Grant_Id   (Grant_Id),
    .Fib_Rst    (Fib_Rst),
    .Fib_Start  (Fib_Start),
    .Fib_Number (Fib_Number),
    .Fib_Result (Fib_Result),
    .Fib_Done   (Fib_Done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] fib_ref(input logic [DW-1:0] n);
    logic [DW-1:0] a, b, t;
    a = '0;
    b = 10'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++)
      if (r[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then refresh the Fib_Seq stub from the new DUT outputs.
  task automatic step();
    @(posedge Clk);
    #1;
    if (Fib_Start) begin
      stub_cnt   = prev_start ? stub_cnt + 1 : 0;
      Fib_Done   = (stub_cnt >= lat);
      Fib_Result = fib_ref(Fib_Number);
    end else begin
      stub_cnt   = 0;
      Fib_Done   = 1'($urandom_range(0, 1));
      Fib_Result = 10'($urandom);
    end
    prev_start = Fib_Start;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    step();
    step();
    Rst    = 1'b1;
    last_g = NR - 1;
  endtask

  // One job from an IDLE cycle whose Req already selects g.
  // mode: 0 keep Req, 1 drop Req[g] at Ack, 2 drop Req[g] and change Number[g] in RUN, 3 drop all at Ack.
  task automatic serve(input int g, input logic [DW-1:0] exp_res, input int l,
                       input int exp_edges, input logic exp_err, input int mode);
    int e;
    logic [DW-1:0] exp_num;
    exp_num = Number[g*DW +: DW];
    lat = l;
    step();
    e = 1;
    check("load_rst", 32'(Fib_Rst), 1);
    check("load_start", 32'(Fib_Start), 0);
    check("load_busy", 32'(Busy), 1);
    check("load_gid", 32'(Grant_Id), g);
    check("load_num", 32'(Fib_Number), 32'(exp_num));
    step();
    e = 2;
    check("run_rst", 32'(Fib_Rst), 0);
    check("run_start", 32'(Fib_Start), 1);
    check("run_ack", 32'(Ack), 0);
    if (mode == 2) begin
      Req[g] = 1'b0;
      Number[g*DW +: DW] = exp_num + 10'd1;
    end
    while (Ack == '0 && e < 80) begin
      step();
      e++;
      if (Ack == '0) check("run_hold", 32'(Fib_Start), 1);
    end
    check("ack_lat", e, exp_edges);
    check("ack_vec", 32'(Ack), 32'(1 << g));
    check("ack_res", 32'(Result), 32'(exp_res));
    check("ack_err", 32'(Err), 32'(exp_err));
    check("resp_rst", 32'(Fib_Rst), 1);
    check("resp_start", 32'(Fib_Start), 0);
    if (mode == 1) Req[g] = 1'b0;
    if (mode == 3) Req = '0;
    last_g = g;
    step();
    check("idle_ack", 32'(Ack), 0);
    check("idle_busy", 32'(Busy), 0);
    check("idle_err", 32'(Err), 0);
    check("res_hold", 32'(Result), 32'(exp_res));
  endtask

  function automatic int edges_for(input int l);
    return 3 + ((l < 1) ? 1 : l);
  endfunction

  initial begin
    int g;
    int l;
    Rst        = 1'b0;
    Req        = '0;
    Number     = '0;
    Fib_Done   = 1'b0;
    Fib_Result = '0;

    // Reset state
    step();
    step();
    check("rst_ack", 32'(Ack), 0);
    check("rst_err", 32'(Err), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_res", 32'(Result), 0);
    check("rst_gid", 32'(Grant_Id), 0);
    check("rst_frst", 32'(Fib_Rst), 1);
    check("rst_fstart", 32'(Fib_Start), 0);
    check("rst_fnum", 32'(Fib_Number), 0);
    Rst = 1'b1;
    step();
    check("idle_noreq", 32'(Busy), 0);

    // Single job: fib(10) = 55
    Number[0*DW +: DW] = 10'd10;
    Req = 4'b0001;
    g = rr_pick(Req, last_g);
    serve(g, 10'd55, 2, edges_for(2), 1'b0, 1);

    // Four simultaneous requests after a fresh reset
    do_reset();
    for (int i = 0; i < NR; i++) Number[i*DW +: DW] = 10'(i + 1);
    Req = 4'b1111;
    for (int j = 0; j < NR; j++) begin
      g = rr_pick(Req, last_g);
      l = (j == 0) ? 0 : j;
      serve(g, fib_ref(Number[g*DW +: DW]), l, edges_for(l), 1'b0, 1);
    end

    // Fairness: 0 and 2 held across six jobs
    Number[0*DW +: DW] = 10'd7;
    Number[2*DW +: DW] = 10'd9;
    Req = 4'b0101;
    for (int j = 0; j < 6; j++) begin
      g = rr_pick(Req, last_g);
      serve(g, fib_ref(Number[g*DW +: DW]), 1, edges_for(1), 1'b0, (j == 5) ? 3 : 0);
    end

    // Req drop and Number change during RUN
    Number[1*DW +: DW] = 10'd7;
    Req = 4'b0010;
    g = rr_pick(Req, last_g);
    serve(g, 10'd13, 3, edges_for(3), 1'b0, 2);
    for (int j = 0; j < 3; j++) begin
      step();
      check("drop_busy", 32'(Busy), 0);
      check("drop_ack", 32'(Ack), 0);
    end

    // Reset mid-RUN abandons the job
    Number[3*DW +: DW] = 10'd5;
    Req = 4'b1000;
    lat = 3;
    step();
    step();
    step();
    check("mr_run", 32'(Fib_Start), 1);
    check("mr_noack", 32'(Ack), 0);
    Rst = 1'b0;
    Req = '0;
    step();
    check("mr_busy", 32'(Busy), 0);
    check("mr_frst", 32'(Fib_Rst), 1);
    check("mr_ack", 32'(Ack), 0);
    check("mr_gid", 32'(Grant_Id), 0);
    Rst    = 1'b1;
    last_g = NR - 1;
    Number[0*DW +: DW] = 10'd6;
    Req = 4'b1001;
    g = rr_pick(Req, last_g);
    serve(g, fib_ref(Number[g*DW +: DW]), 2, edges_for(2), 1'b0, 1);
    g = rr_pick(Req, last_g);
    serve(g, fib_ref(Number[g*DW +: DW]), 0, edges_for(0), 1'b0, 1);

    // Randomized traffic, including results that overflow DATA_W
    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < NR; i++) begin
        if (!Req[i] && $urandom_range(0, 1) == 1) begin
          Req[i] = 1'b1;
          Number[i*DW +: DW] = 10'($urandom_range(0, 30));
        end
      end
      if (Req == '0) begin
        g = $urandom_range(0, NR - 1);
        Req[g] = 1'b1;
        Number[g*DW +: DW] = 10'($urandom_range(0, 30));
      end
      g = rr_pick(Req, last_g);
      l = $urandom_range(0, 4);
      serve(g, fib_ref(Number[g*DW +: DW]), l, edges_for(l), 1'b0,
            ($urandom_range(0, 1) == 1) ? 1 : 0);
    end
    Req = '0;
    step();
    step();

`ifdef FIB_ARB_TIMEOUT_EN
    // Watchdog: Fib_Done never honoured
    Number[2*DW +: DW] = 10'd9;
    Req = 4'b0100;
    g = rr_pick(Req, last_g);
    serve(g, 10'h3FF, 1000, 2 + TO, 1'b1, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
